// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and state encoding for the FND BCD converter.
package fnd_pkg;
   localparam int IN_W = 32;
   localparam int DIGITS = 6;
   localparam int MAG_W = 20;
   localparam int DIG_W = 4;
   localparam int CNT_W = $clog2(MAG_W + 1);
   localparam int POS_LIMIT = 999999;
   localparam int NEG_LIMIT = -99999;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: one double-dabble nibble correction, adds 3 when the digit is 5 or more.
module bcd_add3
   import fnd_pkg::*;
(
   input  logic [DIG_W-1:0] d,
   output logic [DIG_W-1:0] q
);
   assign q = (d >= DIG_W'(5)) ? d + DIG_W'(3) : d;
endmodule

// File: rtl/fnd_bcd_converter.sv
// fnd_bcd_converter: signed binary to packed BCD via double dabble, holding digits for display.
// Optional LEADING_ZERO_BLANK_EN adds a blank[] output marking leading-zero digits.
module fnd_bcd_converter
   import fnd_pkg::*;
(
   input  logic                    fnd_clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [IN_W-1:0]         bin_in,
   output logic [DIG_W*DIGITS-1:0] bcd_out,
   output logic                    neg,
   output logic                    ovf,
   output logic                    busy,
   output logic                    done
`ifdef LEADING_ZERO_BLANK_EN
   ,output logic [DIGITS-1:0]      blank
`endif
);
   localparam int BCD_W = DIG_W * DIGITS;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [MAG_W-1:0]   mag_q, mag_d;
   logic [BCD_W-1:0]   acc_q, acc_d, acc_fix;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               neg_c_q, neg_c_d, ovf_c_q, ovf_c_d;
   logic               neg_q, neg_d, ovf_q, ovf_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               in_ovf;
   logic [MAG_W-1:0]   in_mag;
   // Range check on the raw signed value so -2^31 never reaches the negation.
   assign in_ovf = ($signed(bin_in) > POS_LIMIT) || ($signed(bin_in) < NEG_LIMIT);
   assign in_mag = MAG_W'(bin_in[IN_W-1] ? -bin_in : bin_in);
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (.d(acc_q[DIG_W*g +: DIG_W]), .q(acc_fix[DIG_W*g +: DIG_W]));
   end
`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d, lz;
   logic              z;
   always_comb begin
      lz = '0;
      z = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         z = z & (acc_q[DIG_W*i +: DIG_W] == '0);
         lz[i] = z;
      end
   end
   assign blank = blank_q;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      mag_d = mag_q;
      acc_d = acc_q;
      bcd_d = bcd_q;
      neg_c_d = neg_c_q;
      ovf_c_d = ovf_c_q;
      neg_d = neg_q;
      ovf_d = ovf_q;
      done_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_d = blank_q;
`endif
      case (state_q)
         IDLE: if (start && !done_q) begin
            neg_c_d = bin_in[IN_W-1];
            ovf_c_d = in_ovf;
            acc_d = '0;
            mag_d = in_ovf ? '0 : in_mag;
            cnt_d = CNT_W'(MAG_W);
            state_d = in_ovf ? DONE : SHIFT;
         end
         SHIFT: begin
            {acc_d, mag_d} = {acc_fix[BCD_W-2:0], mag_q, 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
         end
         DONE: begin
            bcd_d = acc_q;
            neg_d = neg_c_q;
            ovf_d = ovf_c_q;
            done_d = 1'b1;
            state_d = IDLE;
`ifdef LEADING_ZERO_BLANK_EN
            blank_d = ovf_c_q ? '0 : lz;
`endif
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
   end
   always_ff @(posedge fnd_clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         mag_q <= '0;
         acc_q <= '0;
         bcd_q <= '0;
         neg_c_q <= 1'b0;
         ovf_c_q <= 1'b0;
         neg_q <= 1'b0;
         ovf_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         blank_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         mag_q <= mag_d;
         acc_q <= acc_d;
         bcd_q <= bcd_d;
         neg_c_q <= neg_c_d;
         ovf_c_q <= ovf_c_d;
         neg_q <= neg_d;
         ovf_q <= ovf_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef LEADING_ZERO_BLANK_EN
         blank_q <= blank_d;
`endif
      end
   end
   assign bcd_out = bcd_q;
   assign neg = neg_q;
   assign ovf = ovf_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule
